sop_engine: RTL and testbench
=============================

# sop_engine

Parametrised sum-of-products engine: on a one-cycle `start`, it captures PAIRS operand pairs, a per-pair add/subtract mask and a signed/unsigned mode. It then computes Σ ±(aₖ·bₖ) through one registered multiplier and an accumulator, one pair per cycle. It is the generalised successor of the fixed six-input, 32-bit arithmetic top: width, pair count, subtraction and signedness are now configurable. It also reports overflow and busy status.

## Interface
- WIDTH, 32, operand and result width in bits (≥2)
- PAIRS, 3, number of operand pairs (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- operands  in  2·PAIRS·WIDTH  flat bus; pair k: aₖ = bits [(2k+1)·WIDTH-1 : 2k·WIDTH], bₖ = bits [(2k+2)·WIDTH-1 : (2k+1)·WIDTH]
- sub_mask  in  PAIRS  bit k=1 → product k is subtracted
- signed_mode  in  1  1 = two's-complement operands and result; 0 = unsigned
- result  out  WIDTH  low WIDTH bits of final sum; held until next completion
- overflow  out  1  final sum not representable in WIDTH bits under the captured mode
- busy  out  1  high while a computation is in progress
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE + start=1 at an edge:
  - Capture operands, sub_mask and signed_mode into internal registers.
  - Clear idx, accumulator and product-valid flag; go to RUN.
  - Input changes after this edge have no effect.
- RUN, each edge:
  - Register the product of pair idx as p_reg, sign-extended or zero-extended per captured mode.
  - If p_reg is valid, accumulate it: add, or subtract when its mask bit is set.
  - Increment idx. When idx = PAIRS-1, go to DRAIN.
- DRAIN, one edge:
  - Accumulate the last p_reg.
  - Load result from the final sum, low WIDTH bits, and load overflow.
  - Pulse done; return to IDLE.
- Accumulator width ACC_W = 2·WIDTH + clog2(PAIRS) + 1. It never wraps internally.
- Overflow:
  - Signed: sum < -2^(WIDTH-1) or sum > 2^(WIDTH-1)-1.
  - Unsigned: sum < 0 (net subtraction) or sum ≥ 2^WIDTH.
- start in RUN or DRAIN is ignored, with no queueing.
- start in the cycle where done=1 is accepted, because the FSM is already in IDLE.
- PAIRS=1: RUN lasts one edge, then DRAIN.

## Timing
- Reset (rst=0, asynchronous):
  - Outputs: result=0, overflow=0, busy=0, done=0.
  - Internal: state=IDLE; idx, accumulator and p_reg cleared.
  - Reset mid-operation abandons the computation; no done pulse is produced.
- Latency: start sampled at edge E0; done=1 and result/overflow valid after edge E(PAIRS+1). For PAIRS=3, done rises 4 edges after the start edge.
- busy is high from E0 through E(PAIRS) and low in the done cycle.
- done is high for exactly one cycle.
- result and overflow change only at DRAIN edges or on reset.
- Back-to-back throughput: one computation per PAIRS+1 cycles.

## Structure
- Package sop_pkg holds:
  - State enum {IDLE, RUN, DRAIN}.
  - clog2 function.
  - ACC_W derivation function.
- Sub-module sop_mult: registered WIDTH×WIDTH multiplier with signed_mode select and 2·WIDTH output. It is instantiated once, with the index multiplexer feeding it.
- Top holds the FSM, operand/mask capture registers, the accumulator and the overflow check.

## Test plan
- WIDTH=32, PAIRS=3, pairs (2,3),(4,5),(3,2), mask=000, unsigned, start at E0 → result=32, overflow=0, done one cycle after E4, busy high E0–E3.
- Same operands, mask=100 → result=20. Mask=111 with signed_mode=1 → result=-32 (0xFFFFFFE0), overflow=0. Mask=111 with signed_mode=0 → overflow=1.
- WIDTH=8, PAIRS=2, signed, pairs (-128,-128),(0,0) → sum 16384 → overflow=1, result=0x00. Pairs (-8,16),(0,0) → result=-128, overflow=0.
- Second start pulses during busy, then start in the done cycle → busy-time starts ignored; the done-cycle start yields a second done exactly PAIRS+1 edges later. Operands changed after E0 do not alter the result.
- Drive rst=0 mid-RUN → outputs zero immediately and asynchronously, with no done. Then a new start after release computes correctly from scratch.
- PAIRS=1, WIDTH=16, (300,200), unsigned → result=60000, overflow=0, done 2 edges after start.

Source files
------------

// File: rtl/sop_pkg.sv
// sop_pkg: shared types and elaboration-time helpers for the sum-of-products engine.
//   state_t    : FSM encoding (IDLE, RUN, DRAIN)
//   clog2      : ceiling log2, usable in parameter expressions
//   acc_width  : accumulator width that can hold any PAIRS-term sum of products without wrapping
package sop_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Two full products plus growth for PAIRS terms plus one sign bit, so that
    // unsigned sums and net subtractions both stay exact.
    function automatic int acc_width(input int width, input int pairs);
        return 2 * width + clog2(pairs) + 1;
    endfunction

endpackage

// File: rtl/sop_engine_if.sv
// sop_engine_if: request/result bundle between a requester and sop_engine.
//   start, operands, sub_mask, signed_mode : requester -> engine
//   result, overflow, busy, done           : engine -> requester
//   master modport = requester side, slave modport = engine side.
interface sop_engine_if #(
    parameter int WIDTH = 32,
    parameter int PAIRS = 3
);
    logic                       start;
    logic [2*PAIRS*WIDTH-1:0]   operands;
    logic [PAIRS-1:0]           sub_mask;
    logic                       signed_mode;
    logic [WIDTH-1:0]           result;
    logic                       overflow;
    logic                       busy;
    logic                       done;

    modport master (
        output start, operands, sub_mask, signed_mode,
        input  result, overflow, busy, done
    );

    modport slave (
        input  start, operands, sub_mask, signed_mode,
        output result, overflow, busy, done
    );
endinterface

// File: rtl/sop_mult.sv
// sop_mult: registered WIDTH x WIDTH multiplier.
//   clk, rst     : clock, asynchronous active-low reset (clears p_reg)
//   en           : load a new product this edge
//   signed_mode  : 1 = operands are two's complement, 0 = unsigned
//   a, b         : operands
//   p_reg        : registered 2*WIDTH product (exact in either mode)
module sop_mult #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   p_reg
);
    logic [2*WIDTH-1:0] a_ext_s;
    logic [2*WIDTH-1:0] b_ext_s;
    logic [2*WIDTH-1:0] prod_s;

    // Extend operands to the product width; the low 2*WIDTH bits of the
    // product are then correct for both signed and unsigned interpretation.
    always_comb begin
        a_ext_s = {{WIDTH{signed_mode & a[WIDTH-1]}}, a};
        b_ext_s = {{WIDTH{signed_mode & b[WIDTH-1]}}, b};
        prod_s  = a_ext_s * b_ext_s;
    end

    // Product register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_reg <= '0;
        end else if (en) begin
            p_reg <= prod_s;
        end
    end
endmodule

// File: rtl/sop_engine.sv
// sop_engine: computes sum of +/-(a_k * b_k) over PAIRS operand pairs, one pair per cycle.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : sop_engine_if slave (start/operands/sub_mask/signed_mode in,
//              result/overflow/busy/done out)
// start in IDLE captures the request; RUN feeds one pair per edge into the
// registered multiplier while the previous product is accumulated; DRAIN adds
// the final product, loads result/overflow and pulses done.
module sop_engine
    import sop_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int PAIRS = 3
) (
    input  logic          clk,
    input  logic          rst,
    sop_engine_if.slave   bus
);
    localparam int ACC_W = acc_width(WIDTH, PAIRS);
    localparam int P_W   = 2 * WIDTH;
    localparam int IDX_W = (PAIRS > 1) ? clog2(PAIRS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAIRS - 1);

    state_t                     state_r, state_s;
    logic [IDX_W-1:0]           idx_r;
    logic [2*PAIRS*WIDTH-1:0]   ops_r;
    logic [PAIRS-1:0]           mask_r;
    logic                       mode_r;
    logic [ACC_W-1:0]           acc_r;
    logic                       pvld_r;
    logic                       psub_r;
    logic [WIDTH-1:0]           result_r;
    logic                       overflow_r;
    logic                       busy_r;
    logic                       done_r;

    logic [WIDTH-1:0]           a_s, b_s;
    logic                       sub_s;
    logic [P_W-1:0]             p_reg_s;
    logic [ACC_W-1:0]           p_ext_s;
    logic [ACC_W-1:0]           sum_s;
    logic [ACC_W-WIDTH:0]       hi_s;
    logic                       ovf_s;

    // Select the pair (and its mask bit) addressed by idx_r.
    always_comb begin
        a_s   = '0;
        b_s   = '0;
        sub_s = 1'b0;
        for (int k = 0; k < PAIRS; k++) begin
            a_s   = (idx_r == IDX_W'(k)) ? ops_r[2*k*WIDTH +: WIDTH]     : a_s;
            b_s   = (idx_r == IDX_W'(k)) ? ops_r[(2*k+1)*WIDTH +: WIDTH] : b_s;
            sub_s = (idx_r == IDX_W'(k)) ? mask_r[k]                     : sub_s;
        end
    end

    sop_mult #(.WIDTH(WIDTH)) u_mult (
        .clk         (clk),
        .rst         (rst),
        .en          (state_r == RUN),
        .signed_mode (mode_r),
        .a           (a_s),
        .b           (b_s),
        .p_reg       (p_reg_s)
    );

    // Accumulate the registered product when valid, and test the resulting
    // sum against the range of the captured mode.
    always_comb begin
        p_ext_s = {{(ACC_W-P_W){mode_r & p_reg_s[P_W-1]}}, p_reg_s};
        if (pvld_r) begin
            sum_s = psub_r ? (acc_r - p_ext_s) : (acc_r + p_ext_s);
        end else begin
            sum_s = acc_r;
        end
        hi_s = sum_s[ACC_W-1:WIDTH-1];
        if (mode_r) begin
            // Signed fits only when every bit from WIDTH-1 upward equals the sign.
            ovf_s = ~((&hi_s) | ~(|hi_s));
        end else begin
            // Unsigned fits only when nothing is set at or above bit WIDTH
            // (a negative sum has its sign bit set there).
            ovf_s = |sum_s[ACC_W-1:WIDTH];
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = bus.start ? RUN : IDLE;
            RUN:     state_s = (idx_r == LAST_IDX) ? DRAIN : RUN;
            DRAIN:   state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, capture registers, accumulator and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            idx_r      <= '0;
            ops_r      <= '0;
            mask_r     <= '0;
            mode_r     <= 1'b0;
            acc_r      <= '0;
            pvld_r     <= 1'b0;
            psub_r     <= 1'b0;
            result_r   <= '0;
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_r == DRAIN);
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        ops_r  <= bus.operands;
                        mask_r <= bus.sub_mask;
                        mode_r <= bus.signed_mode;
                        idx_r  <= '0;
                        acc_r  <= '0;
                        pvld_r <= 1'b0;
                    end
                end
                RUN: begin
                    acc_r  <= sum_s;
                    pvld_r <= 1'b1;
                    psub_r <= sub_s;
                    idx_r  <= idx_r + IDX_W'(1);
                end
                DRAIN: begin
                    acc_r      <= sum_s;
                    pvld_r     <= 1'b0;
                    result_r   <= sum_s[WIDTH-1:0];
                    overflow_r <= ovf_s;
                end
                default: begin
                    pvld_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.result   = result_r;
    assign bus.overflow = overflow_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
endmodule

// File: tb/tb_sop_engine.sv
// tb_sop_engine: scoreboard bench for three sop_engine configurations
// (32x3, 8x2, 16x1). Expected results come from an arbitrary-precision model
// and are queued with the cycle at which done must appear.
module tb_sop_engine;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    exp_t q0[$], q1[$], q2[$];
    exp_t e0, e1, e2;
    bit   pd0 = 1'b0, pd1 = 1'b0, pd2 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sop_engine_if #(.WIDTH(32), .PAIRS(3)) if0 ();
    sop_engine_if #(.WIDTH(8),  .PAIRS(2)) if1 ();
    sop_engine_if #(.WIDTH(16), .PAIRS(1)) if2 ();

    sop_engine #(.WIDTH(32), .PAIRS(3)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    sop_engine #(.WIDTH(8),  .PAIRS(2)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    sop_engine #(.WIDTH(16), .PAIRS(1)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Exact reference: interpret operands per mode, sum in 130-bit signed.
    function automatic exp_t model(input int w, input int n, input logic [191:0] ops,
                                   input logic [2:0] m, input logic sm, input int c);
        logic signed [129:0] sum, va, vb;
        exp_t e;
        sum = 130'sd0;
        for (int k = 0; k < n; k++) begin
            va = 130'sd0;
            vb = 130'sd0;
            for (int j = 0; j < w; j++) begin
                va[j] = ops[2*k*w + j];
                vb[j] = ops[(2*k+1)*w + j];
            end
            if (sm && va[w-1]) va = va - (130'sd1 <<< w);
            if (sm && vb[w-1]) vb = vb - (130'sd1 <<< w);
            if (m[k]) sum = sum - va * vb;
            else      sum = sum + va * vb;
        end
        if (sm) e.ovf = (sum < -(130'sd1 <<< (w-1))) || (sum > ((130'sd1 <<< (w-1)) - 130'sd1));
        else    e.ovf = (sum < 130'sd0) || (sum >= (130'sd1 <<< w));
        e.res = 32'd0;
        for (int j = 0; j < w; j++) e.res[j] = sum[j];
        e.cyc = c;
        return e;
    endfunction

    // Scoreboard monitors: compare on each done pulse, and check done width.
    always @(negedge clk) begin
        if (pd0) check_eq("d0_pulse_width", if0.done, 1'b0);
        if (if0.done && !pd0) begin
            if (q0.size() == 0) check_eq("d0_spurious_done", if0.done, 1'b0);
            else begin
                e0 = q0.pop_front();
                check_eq("d0_result", if0.result, e0.res);
                check_eq("d0_overflow", if0.overflow, e0.ovf);
                check_eq("d0_latency", cyc, e0.cyc);
                check_eq("d0_busy_in_done", if0.busy, 1'b0);
            end
        end
        pd0 <= if0.done;
    end

    always @(negedge clk) begin
        if (pd1) check_eq("d1_pulse_width", if1.done, 1'b0);
        if (if1.done && !pd1) begin
            if (q1.size() == 0) check_eq("d1_spurious_done", if1.done, 1'b0);
            else begin
                e1 = q1.pop_front();
                check_eq("d1_result", if1.result, e1.res);
                check_eq("d1_overflow", if1.overflow, e1.ovf);
                check_eq("d1_latency", cyc, e1.cyc);
            end
        end
        pd1 <= if1.done;
    end

    always @(negedge clk) begin
        if (pd2) check_eq("d2_pulse_width", if2.done, 1'b0);
        if (if2.done && !pd2) begin
            if (q2.size() == 0) check_eq("d2_spurious_done", if2.done, 1'b0);
            else begin
                e2 = q2.pop_front();
                check_eq("d2_result", if2.result, e2.res);
                check_eq("d2_overflow", if2.overflow, e2.ovf);
                check_eq("d2_latency", cyc, e2.cyc);
            end
        end
        pd2 <= if2.done;
    end

    // Drive tasks: called at a negedge; hold start for one edge, then scramble inputs.
    task automatic drive0(input logic [191:0] ops, input logic [2:0] m, input logic sm, input bit push);
        if0.start = 1'b1; if0.operands = ops; if0.sub_mask = m; if0.signed_mode = sm;
        if (push) q0.push_back(model(32, 3, ops, m, sm, cyc + 5));
        @(negedge clk);
        if0.start = 1'b0;
        if0.operands = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        if0.sub_mask = 3'($urandom);
        if0.signed_mode = ~sm;
    endtask

    task automatic drive1(input logic [15:0] ops, input logic [1:0] m, input logic sm);
        if1.start = 1'b1; if1.operands = ops; if1.sub_mask = m; if1.signed_mode = sm;
        q1.push_back(model(8, 2, {176'd0, ops}, {1'b0, m}, sm, cyc + 4));
        @(negedge clk);
        if1.start = 1'b0;
        if1.operands = 16'($urandom);
        if1.sub_mask = 2'($urandom);
        if1.signed_mode = ~sm;
    endtask

    task automatic drive2(input logic [31:0] ops, input logic m, input logic sm);
        if2.start = 1'b1; if2.operands = ops; if2.sub_mask = m; if2.signed_mode = sm;
        q2.push_back(model(16, 1, {160'd0, ops}, {2'b00, m}, sm, cyc + 3));
        @(negedge clk);
        if2.start = 1'b0;
        if2.operands = $urandom;
        if2.sub_mask = 1'($urandom);
        if2.signed_mode = ~sm;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) check_eq("drain_timeout", 64'(k), 64'd0);
        @(negedge clk);
    endtask

    logic [191:0] ops_a;
    int           k_wait;

    initial begin
        ops_a = {32'd2, 32'd3, 32'd5, 32'd4, 32'd3, 32'd2};
        rst = 1'b0;
        if0.start = 1'b0; if0.operands = '0; if0.sub_mask = '0; if0.signed_mode = 1'b0;
        if1.start = 1'b0; if1.operands = '0; if1.sub_mask = '0; if1.signed_mode = 1'b0;
        if2.start = 1'b0; if2.operands = '0; if2.sub_mask = '0; if2.signed_mode = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_result", if0.result, 32'd0);
        check_eq("rst_overflow", if0.overflow, 1'b0);
        check_eq("rst_busy", if0.busy, 1'b0);
        check_eq("rst_done", if0.done, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // Basic 32x3 unsigned with busy profile.
        drive0(ops_a, 3'b000, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check_eq("d0_busy_run", if0.busy, 1'b1);
            check_eq("d0_done_early", if0.done, 1'b0);
            @(negedge clk);
        end
        check_eq("d0_done_cycle", if0.done, 1'b1);
        check_eq("d0_result_32", if0.result, 32'd32);
        wait_drain();

        drive0(ops_a, 3'b100, 1'b0, 1'b1); wait_drain();
        drive0(ops_a, 3'b111, 1'b1, 1'b1); wait_drain();
        drive0(ops_a, 3'b111, 1'b0, 1'b1); wait_drain();
        for (int i = 0; i < 4; i++) begin
            drive0({$urandom, $urandom, 32'($urandom_range(0, 99)), 32'($urandom_range(0, 99)),
                    $urandom, $urandom}, 3'($urandom), 1'($urandom), 1'b1);
            wait_drain();
        end

        // 8x2 signed boundaries, then random.
        drive1({8'd0, 8'd0, 8'h80, 8'h80}, 2'b00, 1'b1); wait_drain();
        drive1({8'd0, 8'd0, 8'd16, 8'hF8}, 2'b00, 1'b1); wait_drain();
        for (int i = 0; i < 4; i++) begin
            drive1(16'($urandom), 2'($urandom), 1'($urandom)); wait_drain();
        end

        // 16x1.
        drive2({16'd200, 16'd300}, 1'b0, 1'b0); wait_drain();
        for (int i = 0; i < 3; i++) begin
            drive2($urandom, 1'($urandom), 1'($urandom)); wait_drain();
        end

        // Starts while busy are ignored; start in the done cycle is accepted.
        drive0({32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2}, 3'b010, 1'b0, 1'b1);
        drive0(ops_a, 3'b000, 1'b0, 1'b0);
        drive0(ops_a, 3'b111, 1'b1, 1'b0);
        k_wait = 0;
        while (!if0.done && k_wait < 20) begin
            @(negedge clk);
            k_wait++;
        end
        check_eq("d0_b2b_done_seen", if0.done, 1'b1);
        drive0(ops_a, 3'b000, 1'b0, 1'b1);
        wait_drain();

        // Asynchronous reset mid-RUN: outputs clear at once, no done follows.
        drive0({32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9}, 3'b000, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_eq("d0_arst_result", if0.result, 32'd0);
        check_eq("d0_arst_overflow", if0.overflow, 1'b0);
        check_eq("d0_arst_busy", if0.busy, 1'b0);
        check_eq("d0_arst_done", if0.done, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("d0_arst_no_done", if0.done, 1'b0);
        drive0({32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15}, 3'b001, 1'b1, 1'b1);
        wait_drain();

        check_eq("queues_empty", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
